// File: rtl/button_entry_unit.sv
// Button entry front end: synchronizes and debounces three active-low buttons,
// shifts in one bit per bit-button press and commits each value to the operand
// memory on a "next" press. Asserts done after DEPTH commits.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_ENTRY  | collecting bits into shift_val, waiting for next
// ST_COMMIT | one-cycle memory write of the assembled value
// ST_DONE   | all entries written, presses ignored until reset
module button_entry_unit #(
   parameter int DATA_W  = 8,
   parameter int DEPTH   = 16,
   parameter int ADDR_W  = 4,
   parameter int DEB_CYC = 8
) (
   input  logic              CLK,
   input  logic              RSTn,
   input  logic [2:0]        btn_n,
   input  logic              en,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic [DATA_W-1:0] shift_val,
   output logic [3:0]        bit_cnt,
   output logic              vec_sel,
   output logic              done
);

   localparam int CNT_W = $clog2(DEB_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYC - 1);
   localparam int ENT_W = ADDR_W + 1;
   localparam logic [3:0] BITS_MAX = 4'(DATA_W);

   typedef enum logic [1:0] {ST_ENTRY, ST_COMMIT, ST_DONE} state_t;

   logic [2:0]       sync1_q, sync2_q, deb_q, deb_d, deb_dly_q, press_q, press_d;
   logic [CNT_W-1:0] deb_cnt_q [3];
   logic [CNT_W-1:0] deb_cnt_d [3];

   state_t            state_q, state_d;
   logic [DATA_W-1:0] shift_q, shift_d, wr_data_q, wr_data_d;
   logic [3:0]        bits_q, bits_d;
   logic [ENT_W-1:0]  ent_q, ent_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic              wr_en_q, wr_en_d, vec_sel_q, vec_sel_d, done_q, done_d;

   // Debounce: a level change is accepted only after DEB_CYC consecutive
   // differing synced samples; a press is the debounced falling edge.
   always_comb begin
      deb_d     = deb_q;
      deb_cnt_d = deb_cnt_q;
      for (int i = 0; i < 3; i++) begin
         if (sync2_q[i] != deb_q[i]) begin
            if (deb_cnt_q[i] == CNT_LAST) begin
               deb_d[i]     = sync2_q[i];
               deb_cnt_d[i] = '0;
            end else begin
               deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
            end
         end else begin
            deb_cnt_d[i] = '0;
         end
      end
      press_d = deb_dly_q & ~deb_q;
   end

   // Synchronizer, debounce and press-pulse registers.
   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         sync1_q   <= '1;
         sync2_q   <= '1;
         deb_q     <= '1;
         deb_dly_q <= '1;
         press_q   <= '0;
         for (int i = 0; i < 3; i++) deb_cnt_q[i] <= '0;
      end else begin
         sync1_q   <= btn_n;
         sync2_q   <= sync1_q;
         deb_q     <= deb_d;
         deb_dly_q <= deb_q;
         press_q   <= press_d;
         deb_cnt_q <= deb_cnt_d;
      end
   end

   // Entry FSM next state; simultaneous presses fall into the default arm
   // and are dropped, as are presses while en is low or outside ST_ENTRY.
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bits_d    = bits_q;
      ent_d     = ent_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      vec_sel_d = vec_sel_q;
      done_d    = done_q;
      case (state_q)
         ST_ENTRY: begin
            if (en) begin
               case (press_q)
                  3'b001, 3'b010: begin
                     shift_d = {shift_q[DATA_W-2:0], press_q[1]};
                     bits_d  = (bits_q == BITS_MAX) ? BITS_MAX : bits_q + 4'd1;
                  end
                  3'b100: begin
                     if (bits_q != 4'd0) begin
                        state_d   = ST_COMMIT;
                        wr_en_d   = 1'b1;
                        wr_addr_d = ent_q[ADDR_W-1:0];
                        wr_data_d = shift_q;
                     end
                  end
                  default: ;
               endcase
            end
         end
         ST_COMMIT: begin
            shift_d   = '0;
            bits_d    = 4'd0;
            ent_d     = ent_q + 1'b1;
            vec_sel_d = (ent_d >= ENT_W'(DEPTH / 2));
            if (ent_d == ENT_W'(DEPTH)) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
            end else begin
               state_d = ST_ENTRY;
            end
         end
         default: ;
      endcase
   end

   // Entry FSM state and registered outputs.
   always_ff @(posedge CLK) begin
      if (!RSTn) begin
         state_q   <= ST_ENTRY;
         shift_q   <= '0;
         bits_q    <= 4'd0;
         ent_q     <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         vec_sel_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bits_q    <= bits_d;
         ent_q     <= ent_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         vec_sel_q <= vec_sel_d;
         done_q    <= done_d;
      end
   end

   assign wr_en     = wr_en_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign shift_val = shift_q;
   assign bit_cnt   = bits_q;
   assign vec_sel   = vec_sel_q;
   assign done      = done_q;

endmodule

// File: doc/button_entry_unit.md
Name: button_entry_unit

Overview:
Front-end input stage of term_project_top, feeding the 16-entry operand memory (vector A at addresses 0-7, vector B at addresses 8-15). It synchronizes and debounces the raw active-low buttons, assembles an 8-bit value one bit per press, and issues one memory write per "next" press. After 16 writes it asserts done to the controller, which then starts computation.

Parameters:
DATA_W, 8, width of one entered value and of wr_data
DEPTH, 16, number of entries written before done
ADDR_W, 4, width of wr_addr
DEB_CYC, 8, consecutive stable synced cycles required to accept a level change (board build overrides to about 1 ms worth of cycles)

Ports:
CLK  in  1  system clock, all logic on rising edge
RSTn  in  1  synchronous active-low reset
btn_n  in  3  raw active-low buttons: [0] enter bit 0, [1] enter bit 1, [2] next/commit
en  in  1  controller permits entry; when low, press events are discarded
wr_en  out  1  one-cycle memory write strobe
wr_addr  out  ADDR_W  write address = entries already committed
wr_data  out  DATA_W  value being committed
shift_val  out  DATA_W  partial value being assembled (for 7-seg/LED)
bit_cnt  out  4  bits entered into shift_val, saturates at 8
vec_sel  out  1  0 while entering A (entries 0-7), 1 for B (8-15)
done  out  1  all DEPTH entries written; held until reset

Behaviour:
- Reset (RSTn low at a CLK edge): all of the following take effect on that edge, regardless of state.
  - shift_val=0, bit_cnt=0, wr_en=0, wr_addr=0, wr_data=0, entry count=0, vec_sel=0, done=0, FSM=ENTRY.
  - Synchronizers and debounced levels reset to 1 (released); debounce counters reset to 0.
- Sync/debounce, per button:
  - 2-flop synchronizer, then a counter that increments while synced != debounced and clears when they are equal.
  - When the counter reaches DEB_CYC, the debounced level flips and the counter clears.
  - Press event = debounced 1->0 transition, a one-cycle pulse. Releases generate nothing.
- Latency: a clean press whose first low sample is at edge t updates shift_val at edge t+DEB_CYC+3. No other latency is legal.
- FSM states:
  - ENTRY:
    - bit press (exactly one of btn 0/1) -> shift_val <= {shift_val[6:0], b}; bit_cnt <= min(bit_cnt+1, 8). More than 8 bits keeps the last 8.
    - next press with bit_cnt != 0 -> COMMIT.
    - next press with bit_cnt == 0 -> ignored, no write.
  - COMMIT (exactly 1 cycle):
    - wr_en=1, wr_addr=entry count, wr_data=shift_val.
    - Next edge: shift_val=0, bit_cnt=0, entry count+1; vec_sel=1 once entry count reaches 8.
    - Go to DONE if the new count == DEPTH, else ENTRY.
  - DONE: done=1; all presses ignored; only reset exits.
- Simultaneous press events (two or more pulses on one cycle): all are discarded, no state change.
- en low: press pulses are discarded, but debounce still tracks the buttons. A press completed while en is low does not fire later when en rises.
- Press events arriving during COMMIT are discarded.
- wr_en is never asserted in two consecutive cycles and never without a preceding accepted next press.
- Reset mid-operation: the partial value and all committed count are lost; memory contents are not this block's concern.
  - A button held low through reset release is seen as a new press DEB_CYC+3 cycles later.

Test Plan:
- Reset, then 8 bit presses 0,0,0,0,0,1,0,1 followed by next (each held 20 cycles, released 20) -> exactly one wr_en pulse with wr_addr=0, wr_data=8'd5; afterwards shift_val=0, bit_cnt=0.
- Full sequence: values 1..8, then 2 eight times -> 16 writes at addresses 0..15 with data 1..8,2..2; vec_sel rises after the 8th write; done=1 after the 16th. Further presses give no wr_en.
- Bounce: btn_n[1] low for DEB_CYC-1 cycles, high for 2 cycles, repeated 5 times -> no shift_val change. A clean low held for DEB_CYC+5 cycles -> exactly one bit, arriving at latency DEB_CYC+3.
- Edge input cases:
  - next with bit_cnt=0 -> no wr_en.
  - 10 bits 1,1,0,0,0,0,0,0,1,1 then next -> wr_data=8'h03.
  - btn 0 and btn 1 pressed together -> bit_cnt unchanged.
- en=0 during a full press of btn 1, then en=1 -> shift_val and bit_cnt unchanged, no late event.
- Reset after 3 committed entries plus 5 partial bits -> all outputs at reset values. The next commit writes addr 0.
